// File: rtl/fp_sched_pkg.sv
// Shared types for the FP unit arbiter: FSM states, default operand width
// and the operand-handshake flag record.
package fp_sched_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  // Sticky record of which operand the FP unit has already accepted
  typedef struct packed {
    logic a_done;
    logic b_done;
  } hs_flags_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the first asserted request at or
// after the pointer, wrapping around once.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDXW-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDXW-1:0]  o_idx
);

  logic            w_found;
  logic [IDXW-1:0] w_pos;

  // Scan requesters starting from the pointer; first hit wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_pos = IDXW'((int'(i_ptr) + int'(i)) % N_REQ);
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_idx        = w_pos;
        o_gnt[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one floating-point unit among N_REQ requesters. Operands and results
// pass through untouched; the block only sequences the handshakes.
module fp_unit_arbiter
  import fp_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = FP_W,
  localparam int IDXW  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_stb,
  output logic [N_REQ-1:0]   req_ack,
  output logic [W-1:0]       req_z,
  output logic [N_REQ-1:0]   req_z_stb,
  input  logic [N_REQ-1:0]   req_z_ack,
  output logic [W-1:0]       unit_a,
  output logic [W-1:0]       unit_b,
  output logic               unit_a_stb,
  output logic               unit_b_stb,
  input  logic               unit_a_ack,
  input  logic               unit_b_ack,
  input  logic [W-1:0]       unit_z,
  input  logic               unit_z_stb,
  output logic               unit_z_ack,
  output logic [IDXW-1:0]    grant_id,
  output logic               busy
);

  state_t           r_state;
  hs_flags_t        r_flags;
  logic [IDXW-1:0]  r_ptr;
  logic [IDXW-1:0]  r_gid;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_z;
  logic [N_REQ-1:0] r_req_ack;
  logic [N_REQ-1:0] r_z_stb;
  logic             r_a_stb;
  logic             r_b_stb;
  logic             r_zack;
  logic             r_busy;

  logic [N_REQ-1:0] w_gnt;
  logic [IDXW-1:0]  w_idx;
  logic [N_REQ-1:0] w_gid_oh;
  logic             w_a_done;
  logic             w_b_done;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req (req_stb),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // An operand counts as delivered once recorded, or in the cycle its ack is sampled
  assign w_a_done = r_flags.a_done | (r_a_stb & unit_a_ack);
  assign w_b_done = r_flags.b_done | (r_b_stb & unit_b_ack);
  assign w_gid_oh = N_REQ'(1) << r_gid;

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_flags   <= '0;
      r_ptr     <= '0;
      r_gid     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_z       <= '0;
      r_req_ack <= '0;
      r_z_stb   <= '0;
      r_a_stb   <= 1'b0;
      r_b_stb   <= 1'b0;
      r_zack    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_req_ack <= '0;
      r_zack    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_stb) begin
            r_gid     <= w_idx;
            r_ptr     <= (w_idx == IDXW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_a       <= req_a[int'(w_idx)*W +: W];
            r_b       <= req_b[int'(w_idx)*W +: W];
            r_req_ack <= w_gnt;
            r_a_stb   <= 1'b1;
            r_b_stb   <= 1'b1;
            r_flags   <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_a_stb && unit_a_ack) begin
            r_a_stb        <= 1'b0;
            r_flags.a_done <= 1'b1;
          end
          if (r_b_stb && unit_b_ack) begin
            r_b_stb        <= 1'b0;
            r_flags.b_done <= 1'b1;
          end
          if (w_a_done && w_b_done) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (unit_z_stb) begin
            r_z     <= unit_z;
            r_zack  <= 1'b1;
            r_z_stb <= w_gid_oh;
            r_state <= S_RETURN;
          end
        end
        S_RETURN: begin
          if (req_z_ack[r_gid]) begin
            r_z_stb <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack    = r_req_ack;
  assign req_z      = r_z;
  assign req_z_stb  = r_z_stb;
  assign unit_a     = r_a;
  assign unit_b     = r_b;
  assign unit_a_stb = r_a_stb;
  assign unit_b_stb = r_b_stb;
  assign unit_z_ack = r_zack;
  assign grant_id   = r_gid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a behavioural FP multiplier model
// whose operand-ack and result latencies are set per test.
module tb_fp_unit_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [3:0]   req_stb = '0;
  logic [3:0]   req_ack;
  logic [31:0]  req_z;
  logic [3:0]   req_z_stb;
  logic [3:0]   req_z_ack = '0;
  logic [31:0]  unit_a;
  logic [31:0]  unit_b;
  logic         unit_a_stb;
  logic         unit_b_stb;
  logic         unit_a_ack = 1'b0;
  logic         unit_b_ack = 1'b0;
  logic [31:0]  unit_z = '0;
  logic         unit_z_stb = 1'b0;
  logic         unit_z_ack;
  logic [1:0]   grant_id;
  logic         busy;

  fp_unit_arbiter #(.N_REQ(4), .W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_stb    (req_stb),
    .req_ack    (req_ack),
    .req_z      (req_z),
    .req_z_stb  (req_z_stb),
    .req_z_ack  (req_z_ack),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .unit_a_stb (unit_a_stb),
    .unit_b_stb (unit_b_stb),
    .unit_a_ack (unit_a_ack),
    .unit_b_ack (unit_b_ack),
    .unit_z     (unit_z),
    .unit_z_stb (unit_z_stb),
    .unit_z_ack (unit_z_ack),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- FP unit model ----------------
  int unsigned a_delay = 0, b_delay = 0, z_delay = 0;
  logic [31:0] m_a = '0, m_b = '0;
  bit          m_got_a = 0, m_got_b = 0, m_zpend = 0, m_clear = 0;
  int unsigned m_cnt_a = 0, m_cnt_b = 0, m_zcnt = 0;

  // Hand-computed single-precision products for the operand pairs used here
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: fmul = 32'h40C00000; // 2.0 * 3.0  = 6.0
      {32'h3FC00000, 32'h40000000}: fmul = 32'h40400000; // 1.5 * 2.0  = 3.0
      {32'h3F000000, 32'h41000000}: fmul = 32'h40800000; // 0.5 * 8.0  = 4.0
      {32'hBF800000, 32'h40A00000}: fmul = 32'hC0A00000; // -1.0 * 5.0 = -5.0
      default:                      fmul = 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin : unit_model
    if (rst) begin
      m_clear = 1;
    end else begin
      if (unit_a_stb && unit_a_ack) begin m_got_a = 1; m_a = unit_a; end
      if (unit_b_stb && unit_b_ack) begin m_got_b = 1; m_b = unit_b; end
      if (unit_z_stb && unit_z_ack) m_clear = 1;
    end
    #1;
    if (m_clear) begin
      unit_z_stb = 0; m_zpend = 0; m_got_a = 0; m_got_b = 0; m_clear = 0;
    end
    m_cnt_a    = unit_a_stb ? m_cnt_a + 1 : 0;
    m_cnt_b    = unit_b_stb ? m_cnt_b + 1 : 0;
    unit_a_ack = unit_a_stb && (m_cnt_a > a_delay);
    unit_b_ack = unit_b_stb && (m_cnt_b > b_delay);
    if (m_got_a && m_got_b && !m_zpend) begin m_zpend = 1; m_zcnt = 0; end
    if (m_zpend && !unit_z_stb) begin
      if (m_zcnt >= z_delay) begin
        unit_z     = fmul(m_a, m_b);
        unit_z_stb = 1;
      end else begin
        m_zcnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  typedef struct {
    int unsigned who;
    logic [31:0] a, b, z;
    int unsigned ad, bd, zd, hold;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int unsigned i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic int unsigned idx_of(input logic [3:0] v);
    for (int unsigned i = 0; i < 4; i++) if (v[i]) return i;
    return 99;
  endfunction

  task automatic set_ops(input int unsigned who, input logic [31:0] a, input logic [31:0] b);
    req_a[who*32 +: 32] = a;
    req_b[who*32 +: 32] = b;
  endtask

  task automatic wait_ack(input int unsigned who, output int unsigned n);
    n = 0;
    do begin tick(); n++; end while (req_ack == '0 && n < 30);
    check("req_ack_onehot", {60'd0, req_ack}, {60'd0, oh(who)});
  endtask

  task automatic wait_zstb(input int unsigned who, output int unsigned n);
    n = 0;
    do begin tick(); n++; end while (req_z_stb == '0 && n < 60);
    check("req_z_stb_onehot", {60'd0, req_z_stb}, {60'd0, oh(who)});
  endtask

  task automatic finish_txn(input int unsigned who);
    req_z_ack[who] = 1'b1;
    tick();
    req_z_ack = '0;
    check("z_stb_cleared", {60'd0, req_z_stb}, 64'd0);
    check("idle_after_zack", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_txn(input vec_t v, output int unsigned lat);
    int unsigned n;
    bit bad;
    a_delay = v.ad; b_delay = v.bd; z_delay = v.zd;
    set_ops(v.who, v.a, v.b);
    req_stb[v.who] = 1'b1;
    wait_ack(v.who, n);
    lat = n;
    check("grant_id", {62'd0, grant_id}, 64'(v.who));
    check("unit_a_op", {32'd0, unit_a}, {32'd0, v.a});
    check("unit_b_op", {32'd0, unit_b}, {32'd0, v.b});
    req_stb[v.who] = 1'b0;
    tick();
    lat++;
    check("ack_width", {60'd0, req_ack}, 64'd0);
    wait_zstb(v.who, n);
    lat += n;
    check("req_z", {32'd0, req_z}, {32'd0, v.z});
    bad = 0;
    for (int unsigned k = 0; k < v.hold; k++) begin
      tick();
      if (req_z_stb !== oh(v.who) || req_z !== v.z) bad = 1;
    end
    check("z_hold", {63'd0, bad}, 64'd0);
    finish_txn(v.who);
  endtask

  // ---------------- main sequence ----------------
  int unsigned lat, n, got, zacks;
  bit          bad;
  logic [31:0] zcap;

  initial begin
    vecs[0] = '{who:0, a:32'h40000000, b:32'h40400000, z:32'h40C00000, ad:0, bd:0, zd:0, hold:0};
    vecs[1] = '{who:1, a:32'h3FC00000, b:32'h40000000, z:32'h40400000, ad:1, bd:0, zd:2, hold:3};
    vecs[2] = '{who:2, a:32'h3F000000, b:32'h41000000, z:32'h40800000, ad:0, bd:3, zd:0, hold:1};
    vecs[3] = '{who:3, a:32'hBF800000, b:32'h40A00000, z:32'hC0A00000, ad:2, bd:2, zd:1, hold:0};
    vecs[4] = '{who:0, a:32'hBF800000, b:32'h40A00000, z:32'hC0A00000, ad:0, bd:0, zd:5, hold:2};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_busy",    {63'd0, busy}, 64'd0);
    check("rst_acks",    {56'd0, req_ack, req_z_stb}, 64'd0);
    check("rst_req_z",   {32'd0, req_z}, 64'd0);
    check("rst_unit_ab", {unit_a, unit_b}, 64'd0);
    check("rst_unit_hs", {61'd0, unit_a_stb, unit_b_stb, unit_z_ack}, 64'd0);
    check("rst_grant",   {62'd0, grant_id}, 64'd0);
    rst = 1'b0;

    // All four requesters held high: grants rotate 0,1,2,3,0
    a_delay = 0; b_delay = 0; z_delay = 0;
    for (int unsigned r = 0; r < 4; r++) set_ops(r, vecs[r].a, vecs[r].b);
    req_stb = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      n = 0;
      do begin tick(); n++; end while (req_ack == '0 && n < 30);
      got = idx_of(req_ack);
      check("rr_order", 64'(got), 64'(k % 4));
      if (k == 4) req_stb = '0;
      wait_zstb(k % 4, n);
      check("rr_req_z", {32'd0, req_z}, {32'd0, vecs[k % 4].z});
      finish_txn(k % 4);
    end

    // Table-driven single transactions
    for (int unsigned i = 0; i < 5; i++) begin
      run_txn(vecs[i], lat);
      if (i == 0) check("min_latency_le4", {63'd0, lat <= 4}, 64'd1);
    end

    // Operand acks in different cycles: A at ISSUE cycle 2, B at cycle 5
    a_delay = 1; b_delay = 4; z_delay = 0;
    set_ops(1, vecs[1].a, vecs[1].b);
    req_stb[1] = 1'b1;
    wait_ack(1, n);
    req_stb[1] = 1'b0;
    zacks = 0;
    check("issue_c1_stb", {62'd0, unit_a_stb, unit_b_stb}, 64'b11);
    for (int unsigned k = 2; k <= 6; k++) begin
      tick();
      if (unit_z_ack) zacks++;
      check("issue_a_stb", {63'd0, unit_a_stb}, {63'd0, k <= 2});
      check("issue_b_stb", {63'd0, unit_b_stb}, {63'd0, k <= 5});
    end
    bad = 0;
    n = 0;
    while (req_z_stb == '0 && n < 20) begin
      tick(); n++;
      if (unit_z_ack) zacks++;
      if (unit_a_stb || unit_b_stb) bad = 1;
    end
    check("issue_no_restrobe", {63'd0, bad}, 64'd0);
    check("issue_z_stb", {60'd0, req_z_stb}, {60'd0, oh(1)});
    check("issue_req_z", {32'd0, req_z}, {32'd0, vecs[1].z});
    tick();
    if (unit_z_ack) zacks++;
    check("wait_entered_once", 64'(zacks), 64'd1);
    finish_txn(1);

    // Requester 2 holds off its result ack for 10 cycles while 1 waits
    a_delay = 0; b_delay = 0; z_delay = 0;
    set_ops(2, vecs[2].a, vecs[2].b);
    set_ops(1, vecs[1].a, vecs[1].b);
    req_stb[2] = 1'b1;
    wait_ack(2, n);
    req_stb[2] = 1'b0;
    req_stb[1] = 1'b1;
    wait_zstb(2, n);
    zcap = req_z;
    check("slow_req_z", {32'd0, zcap}, {32'd0, vecs[2].z});
    bad = 0;
    got = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      if (req_z_stb !== oh(2) || req_z !== zcap) bad = 1;
      if (req_ack != '0) got = 1;
    end
    check("slow_hold_10", {63'd0, bad}, 64'd0);
    check("pending_no_ack", 64'(got), 64'd0);
    finish_txn(2);
    wait_ack(1, n);
    check("pending_grant", {62'd0, grant_id}, 64'd1);
    req_stb[1] = 1'b0;
    wait_zstb(1, n);
    check("pending_req_z", {32'd0, req_z}, {32'd0, vecs[1].z});

    // Stray result ack on another index during requester 1's return
    req_z_ack[3] = 1'b1;
    tick();
    req_z_ack = '0;
    check("stray_zack_stb", {60'd0, req_z_stb}, {60'd0, oh(1)});
    check("stray_zack_busy", {63'd0, busy}, 64'd1);
    finish_txn(1);

    // Reset while waiting for the unit's result
    a_delay = 0; b_delay = 0; z_delay = 30;
    set_ops(0, vecs[0].a, vecs[0].b);
    req_stb[0] = 1'b1;
    wait_ack(0, n);
    req_stb[0] = 1'b0;
    tick(); tick();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    check("pre_rst_strobes", {62'd0, unit_a_stb, unit_b_stb}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_strobes", {55'd0, req_ack, req_z_stb, unit_a_stb}, 64'd0);
    check("midrst_unit", {62'd0, unit_b_stb, unit_z_ack}, 64'd0);
    check("midrst_req_z", {32'd0, req_z}, 64'd0);
    bad = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      tick();
      if (req_z_stb != '0 || busy) bad = 1;
    end
    check("midrst_no_result", {63'd0, bad}, 64'd0);
    run_txn(vecs[0], lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
